map_table_ckpt: RTL
===================

Name: map_table_ckpt

Overview:
N-wide register-rename map table with B branch checkpoints. It translates architectural source and destination registers to physical registers, tracks per-mapping ready bits from the CDB, and snapshots the table on each renamed branch. On a mispredict it restores the table in one cycle from the branch's snapshot, and on a retirement flush from the architectural map. It sits between decode/free list and RS/ROB and replaces the single-snapshot map table.

Parameters:
N, 3, rename/CDB ways per cycle
ARCH_REGS, 32, architectural registers; reg 0 hardwired to preg 0, always ready
PHYS_REGS, 64, physical registers; PW = $clog2(PHYS_REGS), AW = $clog2(ARCH_REGS)
B, 4, checkpoint slots; BW = $clog2(B)

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high
rn_valid  in  N  rename way i valid; way 0 is oldest
rn_r1, rn_r2  in  N x AW  source arch regs
rn_dest  in  N x AW  dest arch reg (0 = no dest)
rn_free_preg  in  N x PW  new preg from free list
rn_is_branch  in  N  way i is a branch; at most one bit set per cycle
cdb_valid  in  N  CDB completion valid
cdb_arch  in  N x AW  completing arch reg
cdb_preg  in  N x PW  completing preg
resolve_valid  in  1  branch resolution
resolve_id  in  BW  checkpoint being resolved
resolve_mispredict  in  1  1 = restore and squash, 0 = release
restore_en  in  1  retirement flush
restore_mt  in  ARCH_REGS x PW  architectural map
r1_preg, r2_preg  out  N x PW  source mappings
r1_ready, r2_ready  out  N  source ready bits
t_old  out  N x PW  previous dest mapping
ckpt_full  out  1  no free slot; a branch must not be presented
ckpt_id  out  BW  slot allocated to this cycle's branch
active_mask  out  B  live checkpoint slots

Behaviour:
- State: map[ARCH_REGS] of {preg, ready}; per slot: valid, snapshot map, dep_mask[B] (older live slots at allocation).
- Reset: map[i] = {i, 1}; all slots invalid, dep_mask 0; active_mask 0, ckpt_full 0, ckpt_id 0.
- Lookups are combinational; state updates at the next edge.
- Combinational order per cycle:
  1. CDB pass: for each valid way, set map[cdb_arch].ready = 1 only if map[cdb_arch].preg == cdb_preg; otherwise unchanged. The same rule applies to every valid snapshot.
  2. Rename ways 0..N-1 in order: way i reads the map as updated by ways < i and by step 1. For rn_dest != 0 it writes {rn_free_preg, 0}.
- Arch reg 0: reads always {0, 1}; dest 0 gives t_old = 0 and no write.
- Same dest in two ways: the later way wins; its t_old equals the earlier way's rn_free_preg.
- Branch at way k: snapshot = map after way k's rename (younger ways excluded), with step 1 applied.
  - Allocated slot = lowest-index invalid slot, driven on ckpt_id.
  - dep_mask of the new slot = current active_mask.
  - ckpt_full = all slots valid; a branch presented while full is ignored (precondition violation).
- Correct resolve: slot resolve_id invalid; bit resolve_id cleared in every dep_mask.
- Mispredict:
  - Next map = snapshot[resolve_id] with this cycle's CDB applied.
  - Slot resolve_id and every slot with dep_mask[resolve_id] = 1 are invalidated.
  - This cycle's renames and any allocation are discarded.
- restore_en (highest priority): map[i] = {restore_mt[i], 1}; all slots invalidated; renames and resolves ignored.
- Resolve on an invalid slot: no effect.
- Correct resolve plus allocation in the same cycle: the freed slot is not reusable until the next cycle, and the new dep_mask excludes it.
- Reset mid-operation overrides everything.

Test Plan:
- Reset, read r1 = 5 on way 0 -> r1_preg = 5, r1_ready = 1; dest 0 with free 40 -> t_old = 0, no write.
- Way0 dest 3 <- 40, way1 r1 = 3 and dest 3 <- 41 -> way1 r1_preg = 40, ready 0, t_old = 40; the next cycle read of reg 3 gives 41.
- Rename dest 7 <- 50, branch at way 1 (slot 0), way 2 dest 7 <- 51; CDB (7, 50) next cycle; mispredict slot 0 -> reg 7 reads {50, 1}, active_mask = 0.
- Allocate B branches over B cycles -> ckpt_full = 1.
  - Correct resolve of slot 1 -> full drops next cycle.
  - Mispredict of slot 0 -> all younger slots freed, active_mask = 0.
- CDB (4, 30) while map[4] = 31 -> ready unchanged in the map and in snapshots.
- Same-cycle restore_en and mispredict -> architectural map wins, all ready = 1, all slots free.

Source files
------------

// File: rtl/map_table_ckpt.sv
`default_nettype none
// ============================================================================
// map_table_ckpt : N-wide rename map table with B branch checkpoints,
//                  CDB ready tracking and single-cycle mispredict/flush restore.
// Revision       : 1.0
// ============================================================================
module map_table_ckpt #(
    parameter  int N         = 3,
    parameter  int ARCH_REGS = 32,
    parameter  int PHYS_REGS = 64,
    parameter  int B         = 4,
    localparam int PW        = $clog2(PHYS_REGS),
    localparam int AW        = $clog2(ARCH_REGS),
    localparam int BW        = $clog2(B)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [N-1:0]                 i_rn_valid,
    input  logic [N-1:0][AW-1:0]         i_rn_r1,
    input  logic [N-1:0][AW-1:0]         i_rn_r2,
    input  logic [N-1:0][AW-1:0]         i_rn_dest,
    input  logic [N-1:0][PW-1:0]         i_rn_free_preg,
    input  logic [N-1:0]                 i_rn_is_branch,
    input  logic [N-1:0]                 i_cdb_valid,
    input  logic [N-1:0][AW-1:0]         i_cdb_arch,
    input  logic [N-1:0][PW-1:0]         i_cdb_preg,
    input  logic                         i_resolve_valid,
    input  logic [BW-1:0]                i_resolve_id,
    input  logic                         i_resolve_mispredict,
    input  logic                         i_restore_en,
    input  logic [ARCH_REGS-1:0][PW-1:0] i_restore_mt,
    output logic [N-1:0][PW-1:0]         o_r1_preg,
    output logic [N-1:0][PW-1:0]         o_r2_preg,
    output logic [N-1:0]                 o_r1_ready,
    output logic [N-1:0]                 o_r2_ready,
    output logic [N-1:0][PW-1:0]         o_t_old,
    output logic                         o_ckpt_full,
    output logic [BW-1:0]                o_ckpt_id,
    output logic [B-1:0]                 o_active_mask
);

    logic [PW-1:0]        r_map_preg [ARCH_REGS];
    logic [ARCH_REGS-1:0] r_map_rdy;
    logic [B-1:0]         r_ck_valid;
    logic [PW-1:0]        r_ck_preg  [B][ARCH_REGS];
    logic [ARCH_REGS-1:0] r_ck_rdy   [B];
    logic [B-1:0]         r_ck_dep   [B];

    logic [ARCH_REGS-1:0] w_map_rdy_cdb;
    logic [ARCH_REGS-1:0] w_ck_rdy_cdb [B];
    logic [PW-1:0]        w_ren_preg   [ARCH_REGS];
    logic [ARCH_REGS-1:0] w_ren_rdy;
    logic [PW-1:0]        w_snap_preg  [ARCH_REGS];
    logic [ARCH_REGS-1:0] w_snap_rdy;
    logic                 w_branch;
    logic [BW-1:0]        w_free_id;
    logic                 w_res_hit;
    logic                 w_mispred;
    logic                 w_alloc;
    logic [B-1:0]         w_kill;
    logic [B-1:0]         w_alloc_mask;

    // A completion only marks ready if the mapping still names that preg.
    always_comb begin
        w_map_rdy_cdb = r_map_rdy;
        for (int s = 0; s < B; s++) w_ck_rdy_cdb[s] = r_ck_rdy[s];
        for (int w = 0; w < N; w++) begin
            if (i_cdb_valid[w]) begin
                if (r_map_preg[i_cdb_arch[w]] == i_cdb_preg[w])
                    w_map_rdy_cdb[i_cdb_arch[w]] = 1'b1;
                for (int s = 0; s < B; s++)
                    if (r_ck_preg[s][i_cdb_arch[w]] == i_cdb_preg[w])
                        w_ck_rdy_cdb[s][i_cdb_arch[w]] = 1'b1;
            end
        end
    end

    // Ways rename in age order; each sees the writes of older ways.
    always_comb begin
        w_ren_preg  = r_map_preg;
        w_ren_rdy   = w_map_rdy_cdb;
        w_snap_preg = r_map_preg;
        w_snap_rdy  = w_map_rdy_cdb;
        w_branch    = 1'b0;
        for (int w = 0; w < N; w++) begin
            o_r1_preg[w]  = (i_rn_r1[w] == '0) ? '0 : w_ren_preg[i_rn_r1[w]];
            o_r1_ready[w] = (i_rn_r1[w] == '0) | w_ren_rdy[i_rn_r1[w]];
            o_r2_preg[w]  = (i_rn_r2[w] == '0) ? '0 : w_ren_preg[i_rn_r2[w]];
            o_r2_ready[w] = (i_rn_r2[w] == '0) | w_ren_rdy[i_rn_r2[w]];
            o_t_old[w]    = (i_rn_dest[w] == '0) ? '0 : w_ren_preg[i_rn_dest[w]];
            if (i_rn_valid[w] && i_rn_dest[w] != '0) begin
                w_ren_preg[i_rn_dest[w]] = i_rn_free_preg[w];
                w_ren_rdy[i_rn_dest[w]]  = 1'b0;
            end
            if (i_rn_valid[w] && i_rn_is_branch[w]) begin
                w_branch    = 1'b1;
                w_snap_preg = w_ren_preg;
                w_snap_rdy  = w_ren_rdy;
            end
        end
    end

    always_comb begin
        w_free_id = '0;
        for (int s = B - 1; s >= 0; s--)
            if (!r_ck_valid[s]) w_free_id = BW'(s);
    end

    assign w_res_hit    = i_resolve_valid & r_ck_valid[i_resolve_id];
    assign w_mispred    = w_res_hit & i_resolve_mispredict;
    assign w_alloc      = w_branch & ~o_ckpt_full & ~w_mispred & ~i_restore_en;
    assign w_alloc_mask = w_alloc ? (B'(1) << w_free_id) : '0;

    // A mispredict also frees every slot allocated while the resolved one was live.
    always_comb begin
        w_kill = '0;
        if (w_res_hit) begin
            w_kill[i_resolve_id] = 1'b1;
            if (i_resolve_mispredict)
                for (int s = 0; s < B; s++)
                    if (r_ck_dep[s][i_resolve_id]) w_kill[s] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ARCH_REGS; i++) r_map_preg[i] <= PW'(i);
            r_map_rdy  <= '1;
            r_ck_valid <= '0;
            for (int s = 0; s < B; s++) r_ck_dep[s] <= '0;
        end else if (i_restore_en) begin
            for (int i = 0; i < ARCH_REGS; i++) r_map_preg[i] <= i_restore_mt[i];
            r_map_rdy  <= '1;
            r_ck_valid <= '0;
        end else if (w_mispred) begin
            r_map_preg <= r_ck_preg[i_resolve_id];
            r_map_rdy  <= w_ck_rdy_cdb[i_resolve_id];
            r_ck_valid <= r_ck_valid & ~w_kill;
            for (int s = 0; s < B; s++) r_ck_dep[s] <= r_ck_dep[s] & ~w_kill;
        end else begin
            r_map_preg <= w_ren_preg;
            r_map_rdy  <= w_ren_rdy;
            r_ck_valid <= (r_ck_valid & ~w_kill) | w_alloc_mask;
            for (int s = 0; s < B; s++) begin
                if (w_alloc_mask[s]) r_ck_dep[s] <= r_ck_valid & ~w_kill;
                else                 r_ck_dep[s] <= r_ck_dep[s] & ~w_kill;
            end
        end
    end

    // Snapshot storage needs no reset; validity is tracked by r_ck_valid.
    always_ff @(posedge clock) begin
        for (int s = 0; s < B; s++) begin
            if (w_alloc_mask[s]) begin
                r_ck_preg[s] <= w_snap_preg;
                r_ck_rdy[s]  <= w_snap_rdy;
            end else begin
                r_ck_rdy[s]  <= w_ck_rdy_cdb[s];
            end
        end
    end

    assign o_ckpt_full   = &r_ck_valid;
    assign o_ckpt_id     = w_free_id;
    assign o_active_mask = r_ck_valid;

endmodule
`default_nettype wire
